// File: rtl/four_color_pkg.sv
// Shared definitions for the four-color map solver: map size, color width,
// search state encoding and the mapping from a region pair to its ADJ bit.
package four_color_pkg;

   localparam int N_REGIONS  = 6;
   localparam int COLOR_W    = 2;
   localparam int N_PAIRS    = N_REGIONS * (N_REGIONS - 1) / 2;
   localparam int IDX_W      = 3;
   localparam int PAIR_IDX_W = 4;
   localparam int LED_W      = N_REGIONS * COLOR_W;

   typedef enum logic [1:0] {
      TRY   = 2'd0,
      BACK  = 2'd1,
      FOUND = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Pairs are numbered row by row through the upper triangle:
   // (0,1),(0,2),...,(0,5),(1,2),...,(4,5).
   function automatic logic [PAIR_IDX_W-1:0] pair_index(input int a, input int b);
      int lo;
      int hi;
      lo = (a < b) ? a : b;
      hi = (a < b) ? b : a;
      return PAIR_IDX_W'(lo * (2 * N_REGIONS - 1 - lo) / 2 + hi - lo - 1);
   endfunction

endpackage

// File: rtl/four_color_solver_if.sv
// Board-facing signals of the solver: raw push buttons in, LED display out.
interface four_color_solver_if;
   import four_color_pkg::*;

   logic [4:0]       pb;
   logic [LED_W-1:0] led;

   modport master (output pb, input led);
   modport slave  (input pb, output led);

endinterface

// File: rtl/four_color_solver_pb_debounce.sv
// One push button: two-flop synchronizer, stability counter, and a
// single-cycle pulse when the accepted level rises.
module pb_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic pulse
);

   localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_a;
   logic             sync_b;
   logic             level;
   logic [CNT_W-1:0] cnt;

   // Bring the asynchronous button into the clock domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
      end else begin
         sync_a <= raw;
         sync_b <= sync_a;
      end
   end

   // Accept a new level only after it has differed for DEBOUNCE_CYCLES
   // consecutive cycles; flag a rising acceptance for exactly one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level <= 1'b0;
         cnt   <= '0;
         pulse <= 1'b0;
      end else begin
         pulse <= 1'b0;
         if (sync_b == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= sync_b;
            cnt   <= '0;
            pulse <= sync_b;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/four_color_solver.sv
// Board top: backtracking search for proper 4-colorings of a 6-region map,
// one search step per clock, with the latest solution shown on the LEDs.
module four_color_solver
   import four_color_pkg::*;
#(
   parameter logic [N_PAIRS-1:0] ADJ             = 15'h533F,
   parameter int                 DEBOUNCE_CYCLES = 1000
) (
   input  logic                clk,
   input  logic                rst_n,
   four_color_solver_if.slave  bus
);

   localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(N_REGIONS - 1);
   localparam logic [COLOR_W-1:0] MAX_COLOR = '1;

   logic                restart_pulse;
   logic                next_pulse;
   logic [COLOR_W-1:0]  col [N_REGIONS];
   logic [IDX_W-1:0]    idx;
   logic [LED_W-1:0]    sol;
   logic [LED_W-1:0]    led_reg;
   state_t              state;
   logic                conflict;
   logic [COLOR_W-1:0]  cur_col;
   logic [COLOR_W-1:0]  prev_col;
   logic [LED_W-1:0]    packed_col;
   logic                unused_pb;

   // The reserved buttons are deliberately left unconnected.
   assign unused_pb = ^bus.pb[4:2];

   pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_restart (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (bus.pb[0]),
      .pulse (restart_pulse)
   );

   pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (bus.pb[1]),
      .pulse (next_pulse)
   );

   // Select the colors at the search position and just below it, and pack
   // the full assignment for the solution register.
   always_comb begin
      cur_col    = '0;
      prev_col   = '0;
      packed_col = '0;
      for (int i = 0; i < N_REGIONS; i++) begin
         if (idx == IDX_W'(i))     cur_col  = col[i];
         if (idx == IDX_W'(i + 1)) prev_col = col[i];
         packed_col[i*COLOR_W +: COLOR_W] = col[i];
      end
   end

   // A conflict exists when an earlier adjacent region shares the color
   // currently being tried at idx.
   always_comb begin
      conflict = 1'b0;
      for (int i = 1; i < N_REGIONS; i++) begin
         for (int j = 0; j < i; j++) begin
            if (idx == IDX_W'(i) && ADJ[pair_index(j, i)] && col[j] == col[i])
               conflict = 1'b1;
         end
      end
   end

   // Search FSM: restart wins over everything, otherwise one step per clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_REGIONS; i++) col[i] <= '0;
         idx   <= '0;
         sol   <= '0;
         state <= TRY;
      end else if (restart_pulse) begin
         for (int i = 0; i < N_REGIONS; i++) col[i] <= '0;
         idx   <= '0;
         sol   <= '0;
         state <= TRY;
      end else begin
         case (state)
            TRY: begin
               if (!conflict) begin
                  if (idx == LAST_IDX) begin
                     sol   <= packed_col;
                     state <= FOUND;
                  end else begin
                     idx <= idx + 1'b1;
                     for (int i = 0; i < N_REGIONS; i++)
                        if (IDX_W'(i) == idx + 1'b1) col[i] <= '0;
                  end
               end else if (cur_col != MAX_COLOR) begin
                  for (int i = 0; i < N_REGIONS; i++)
                     if (IDX_W'(i) == idx) col[i] <= cur_col + 1'b1;
               end else begin
                  state <= BACK;
               end
            end
            BACK: begin
               if (idx == '0) begin
                  sol   <= '1;
                  state <= DONE;
               end else begin
                  idx <= idx - 1'b1;
                  if (prev_col != MAX_COLOR) begin
                     for (int i = 0; i < N_REGIONS; i++)
                        if (IDX_W'(i + 1) == idx) col[i] <= prev_col + 1'b1;
                     state <= TRY;
                  end
               end
            end
            FOUND: begin
               // Asking for the next solution behaves like a conflict on
               // the last region.
               if (next_pulse) begin
                  if (cur_col != MAX_COLOR) begin
                     for (int i = 0; i < N_REGIONS; i++)
                        if (IDX_W'(i) == idx) col[i] <= cur_col + 1'b1;
                     state <= TRY;
                  end else begin
                     state <= BACK;
                  end
               end
            end
            DONE: begin
               state <= DONE;
            end
            default: state <= TRY;
         endcase
      end
   end

   // LED register mirrors the solution register only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) led_reg <= '0;
      else        led_reg <= sol;
   end

   assign bus.led = led_reg;

endmodule

// File: tb/tb_four_color_solver.sv
`timescale 1ns/1ps
module tb_four_color_solver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic rst_n_k6;

   four_color_solver_if bus ();
   four_color_solver_if bus_k6 ();

   four_color_solver #(.ADJ(15'h533F), .DEBOUNCE_CYCLES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   four_color_solver #(.ADJ(15'h7FFF), .DEBOUNCE_CYCLES(4)) dut_k6 (
      .clk   (clk),
      .rst_n (rst_n_k6),
      .bus   (bus_k6)
   );

   typedef struct {
      logic [4:0]  pb_val;
      int          hold;
      logic [11:0] exp_led;
      string       name;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   logic [11:0] model_sols[$];
   logic [11:0] exp_q[$];
   vec_t        vecs[6];

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: led=%h required %h", name, act, exp);
      end
   endtask

   function automatic logic [11:0] led_of(input bit k6);
      return k6 ? bus_k6.led : bus.led;
   endfunction

   // Bounded wait for the LED to show a given value; expiry counts as a failure.
   task automatic wait_value(input bit k6, input logic [11:0] val, input int bound, input string name);
      int n;
      n = 0;
      while (led_of(k6) !== val && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (led_of(k6) !== val) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: led=%h required %h", name, led_of(k6), val);
      end
   endtask

   // Bounded wait for the LED to leave a given value.
   task automatic wait_change(input logic [11:0] old, input int bound, input string name);
      int n;
      n = 0;
      while (bus.led === old && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (bus.led === old) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: led=%h stuck, change required", name, old);
      end
   endtask

   // Press "next", wait for the display to move, release, compare with the
   // oldest expected solution in the scoreboard.
   task automatic step_next(input string name);
      logic [11:0] old;
      logic [11:0] exp;
      old = bus.led;
      bus.pb[1] = 1'b1;
      wait_change(old, 9000, name);
      bus.pb[1] = 1'b0;
      repeat (10) @(negedge clk);
      exp = exp_q.pop_front();
      check(name, bus.led, exp);
   endtask

   // Reference list of all proper colorings in lexicographic order,
   // region 0 most significant, encoded in LED layout.
   task automatic build_model(input logic [14:0] adj);
      int c[6];
      int k;
      bit ok;
      logic [11:0] enc;
      model_sols.delete();
      for (int code = 0; code < 4096; code++) begin
         for (int i = 0; i < 6; i++) c[i] = (code >> (2 * (5 - i))) & 3;
         ok = 1'b1;
         k = 0;
         for (int a = 0; a < 6; a++) begin
            for (int b = a + 1; b < 6; b++) begin
               if (adj[k] && c[a] == c[b]) ok = 1'b0;
               k++;
            end
         end
         if (ok) begin
            enc = '0;
            for (int i = 0; i < 6; i++) enc = enc | (12'(c[i]) << (2 * i));
            model_sols.push_back(enc);
         end
      end
   endtask

   initial begin
      vecs[0] = '{pb_val: 5'b00010, hold: 2,  exp_led: 12'hE64, name: "glitch_next_2"};
      vecs[1] = '{pb_val: 5'b00010, hold: 3,  exp_led: 12'hE64, name: "glitch_next_3"};
      vecs[2] = '{pb_val: 5'b00100, hold: 20, exp_led: 12'hE64, name: "reserved_pb2"};
      vecs[3] = '{pb_val: 5'b01000, hold: 20, exp_led: 12'hE64, name: "reserved_pb3"};
      vecs[4] = '{pb_val: 5'b10000, hold: 20, exp_led: 12'hE64, name: "reserved_pb4"};
      vecs[5] = '{pb_val: 5'b11100, hold: 30, exp_led: 12'hE64, name: "reserved_all"};

      build_model(15'h533F);

      bus.pb    = '0;
      bus_k6.pb = '0;
      rst_n     = 1'b1;
      rst_n_k6  = 1'b1;
      #1;
      rst_n    = 1'b0;
      rst_n_k6 = 1'b0;
      #1;
      check("reset_async", bus.led, 12'h000);
      repeat (2) @(negedge clk);
      check("reset_hold", bus.led, 12'h000);
      check("reset_hold_k6", bus_k6.led, 12'h000);
      rst_n = 1'b1;

      // First solution after reset, then it must hold.
      wait_value(1'b0, 12'hE64, 64, "first_solution");
      check("first_solution", bus.led, 12'hE64);
      repeat (20) @(negedge clk);
      check("first_stable", bus.led, 12'hE64);

      // Inputs that must not disturb the display.
      for (int v = 0; v < 6; v++) begin
         bus.pb = vecs[v].pb_val;
         repeat (vecs[v].hold) @(negedge clk);
         bus.pb = '0;
         repeat (12) @(negedge clk);
         check(vecs[v].name, bus.led, vecs[v].exp_led);
      end

      // Second solution, then a couple more before a restart.
      exp_q.push_back(model_sols[1]);
      step_next("next_1");
      check("second_solution", bus.led, 12'hB64);
      exp_q.push_back(model_sols[2]);
      step_next("next_2");
      exp_q.push_back(model_sols[3]);
      step_next("next_3");

      // Restart mid-enumeration: display clears, then search repeats.
      bus.pb[0] = 1'b1;
      wait_value(1'b0, 12'h000, 20, "restart_clear");
      check("restart_clear", bus.led, 12'h000);
      bus.pb[0] = 1'b0;
      wait_value(1'b0, 12'hE64, 64, "restart_first");
      check("restart_first", bus.led, 12'hE64);
      repeat (10) @(negedge clk);

      // Full enumeration to exhaustion.
      for (int k = 1; k < model_sols.size(); k++) begin
         exp_q.push_back(model_sols[k]);
         step_next($sformatf("enum_%0d", k));
      end
      exp_q.push_back(12'hFFF);
      step_next("exhausted");

      // Further next presses are ignored once done.
      for (int r = 0; r < 2; r++) begin
         bus.pb[1] = 1'b1;
         repeat (10) @(negedge clk);
         bus.pb[1] = 1'b0;
         repeat (10) @(negedge clk);
         check("done_hold", bus.led, 12'hFFF);
      end

      // Asynchronous reset clears a non-zero display between clock edges.
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_main", bus.led, 12'h000);
      @(negedge clk);
      rst_n = 1'b1;

      // K6 is not 4-colorable: the search must end exhausted.
      rst_n_k6 = 1'b1;
      wait_value(1'b1, 12'hFFF, 9000, "k6_exhausted");
      check("k6_exhausted", bus_k6.led, 12'hFFF);

      // Reset mid-search on K6, then the search must run to exhaustion again.
      @(negedge clk);
      rst_n_k6 = 1'b0;
      @(negedge clk);
      rst_n_k6 = 1'b1;
      repeat (20) @(negedge clk);
      #2;
      rst_n_k6 = 1'b0;
      #1;
      check("k6_async_reset", bus_k6.led, 12'h000);
      @(negedge clk);
      rst_n_k6 = 1'b1;
      wait_value(1'b1, 12'hFFF, 9000, "k6_rerun");
      check("k6_rerun", bus_k6.led, 12'hFFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
